// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and oversampling constants
//
// Purpose: constants shared by the UART transmitter and receiver.
// Ports:   none (package).

package uart_pkg;

   localparam int UART_NB_STATE = 2;

   // Frame state encodings, common to both directions of the link.
   typedef enum logic [UART_NB_STATE-1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Ticks per bit period and the tick index that lands at mid start bit.
   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-flop synchronizer for one asynchronous bit
//
// Purpose: brings an asynchronous level into the i_clock domain.
//          Every stage resets to 1 so a serial line reads as idle.
// Ports:
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_d        asynchronous input
//   o_q        synchronized output, SYNC_STAGES cycles of latency

module sync_2ff #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - 16x oversampled UART receiver with framing-error flag
//
// Purpose: receives 1 start bit, DBIT data bits (LSB first) and a stop bit
//          of SB_TICK ticks, sampling each bit at its middle.
// Ports:
//   i_clock         system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_s_tick        one-cycle strobe at 16x the baud rate
//   i_rx            asynchronous serial line, idle high
//   o_dout          last received word, held until the next frame completes
//   o_rx_done_tick  one-cycle pulse when a frame completes
//   o_frame_err     one-cycle pulse with o_rx_done_tick when the stop bit was low

module rx_uart
   import uart_pkg::*;
#(
   parameter int DBIT        = 8,
   parameter int SB_TICK     = 16,
   parameter int NB_STATE    = UART_NB_STATE,
   parameter int SYNC_STAGES = 2
) (
   input  logic            i_clock,
   input  logic            i_reset_n,
   input  logic            i_s_tick,
   input  logic            i_rx,
   output logic [DBIT-1:0] o_dout,
   output logic            o_rx_done_tick,
   output logic            o_frame_err
);

   // The tick counter must reach both the data-bit length and the stop length.
   localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
   localparam int S_W   = $clog2(S_MAX);
   localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

   logic                rx_s;
   logic [NB_STATE-1:0] state_q, state_d;
   logic [S_W-1:0]      s_q, s_d;
   logic [N_W-1:0]      n_q, n_d;
   logic [DBIT-1:0]     b_q, b_d;
   logic [DBIT-1:0]     b_shift;
   logic [DBIT-1:0]     dout_q, dout_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   sync_2ff #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_d      (i_rx),
      .o_q      (rx_s)
   );

   // Right shift with the new bit entering the MSB: after DBIT bits the
   // first (LSB-first) bit on the line has reached bit 0.
   generate
      if (DBIT == 1) begin : g_shift_one
         assign b_shift = rx_s;
      end else begin : g_shift_many
         assign b_shift = {rx_s, b_q[DBIT-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         NB_STATE'(IDLE): begin
            // Start detection does not wait for a tick.
            if (!rx_s) begin
               state_d = NB_STATE'(START);
               s_d     = '0;
            end
         end
         NB_STATE'(START): begin
            if (i_s_tick) begin
               if (s_q == S_W'(MID_TICK)) begin
                  // Line back high at mid start bit: a glitch, not a frame.
                  if (!rx_s) begin
                     state_d = NB_STATE'(DATA);
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = NB_STATE'(IDLE);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         NB_STATE'(DATA): begin
            if (i_s_tick) begin
               if (s_q == S_W'(OVERSAMPLE - 1)) begin
                  b_d = b_shift;
                  s_d = '0;
                  if (n_q == N_W'(DBIT - 1)) begin
                     state_d = NB_STATE'(STOP);
                  end else begin
                     n_d = n_q + N_W'(1);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         NB_STATE'(STOP): begin
            if (i_s_tick) begin
               // Leaving at mid stop bit leaves room for a gapless next start.
               if (s_q == S_W'(SB_TICK - 1)) begin
                  state_d = NB_STATE'(IDLE);
                  done_d  = 1'b1;
                  err_d   = ~rx_s;
                  dout_d  = b_q;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         default: begin
            state_d = NB_STATE'(IDLE);
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= NB_STATE'(IDLE);
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign o_dout         = dout_q;
   assign o_rx_done_tick = done_q;
   assign o_frame_err    = err_q;

endmodule

// File: tb/tb_rx_uart.sv
// tb/tb_rx_uart.sv - directed self-checking bench for rx_uart

module tb_rx_uart;
   import uart_pkg::*;

   localparam int BIT_CLK = 64;   // 16 ticks per bit, one tick every 4 clocks
   localparam int LAT_MIN = 604;  // falling start edge to observed done pulse
   localparam int LAT_MAX = 620;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick = 1'b0;
   logic       rx1, rx2;
   logic [7:0] dout1;
   logic       done1, err1;
   logic [6:0] dout2;
   logic       done2, err2;

   int total = 0;
   int bad   = 0;

   int         cyc = 0;
   int         tick_cnt = 0;
   int         cnt1 = 0, cnt2 = 0;
   int         done_cyc1 = 0, done_cyc2 = 0;
   int         stray = 0;
   logic [7:0] last_dout1 = '0;
   logic       last_err1 = 1'b0;
   logic [6:0] last_dout2 = '0;
   logic       last_err2 = 1'b0;
   int         t0;
   int         base;

   always #5 clk = ~clk;

   rx_uart #(
      .DBIT(8), .SB_TICK(16), .NB_STATE(2), .SYNC_STAGES(2)
   ) dut1 (
      .i_clock(clk), .i_reset_n(rst_n), .i_s_tick(tick), .i_rx(rx1),
      .o_dout(dout1), .o_rx_done_tick(done1), .o_frame_err(err1)
   );

   rx_uart #(
      .DBIT(7), .SB_TICK(32), .NB_STATE(2), .SYNC_STAGES(2)
   ) dut2 (
      .i_clock(clk), .i_reset_n(rst_n), .i_s_tick(tick), .i_rx(rx2),
      .o_dout(dout2), .o_rx_done_tick(done2), .o_frame_err(err2)
   );

   // Baud tick: one clock in four, changed on the falling edge.
   always @(negedge clk) begin
      tick_cnt = (tick_cnt + 1) % 4;
      tick = (tick_cnt == 0);
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (done1) begin
         cnt1++;
         last_dout1 = dout1;
         last_err1  = err1;
         done_cyc1  = cyc;
      end
      if (done2) begin
         cnt2++;
         last_dout2 = dout2;
         last_err2  = err2;
         done_cyc2  = cyc;
      end
      if ((err1 && !done1) || (err2 && !done2)) stray++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_range(input string tag, input int got, input int lo, input int hi);
      total++;
      if (got < lo || got > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
      end
   endtask

   // 8N1 frame on rx1; the line is left at the stop level.
   task automatic send1(input logic [7:0] data, input logic stop_val);
      t0 = cyc;
      rx1 = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx1 = data[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rx1 = stop_val;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   // 7-bit frame with two stop bits on rx2.
   task automatic send2(input logic [6:0] data);
      t0 = cyc;
      rx2 = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         rx2 = data[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rx2 = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      rx1   = 1'b1;
      rx2   = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_dout1", 32'(dout1), 32'h0);
      chk("rst_done1", 32'(done1), 32'h0);
      chk("rst_err1", 32'(err1), 32'h0);
      chk("rst_dout2", 32'(dout2), 32'h0);
      rst_n = 1'b1;
      repeat (BIT_CLK) @(negedge clk);

      // Single frame 0xA5 with a good stop bit.
      send1(8'hA5, 1'b1);
      chk("a5_count", 32'(cnt1), 32'd1);
      chk("a5_dout", 32'(last_dout1), 32'hA5);
      chk("a5_err", 32'(last_err1), 32'h0);
      chk_range("a5_latency", done_cyc1 - t0, LAT_MIN, LAT_MAX);
      repeat (BIT_CLK) @(negedge clk);
      chk("a5_held", 32'(dout1), 32'hA5);

      // Back-to-back 0x00 then 0xFF with no idle gap.
      send1(8'h00, 1'b1);
      chk("b2b_first_dout", 32'(last_dout1), 32'h00);
      chk("b2b_first_err", 32'(last_err1), 32'h0);
      send1(8'hFF, 1'b1);
      chk("b2b_count", 32'(cnt1), 32'd3);
      chk("b2b_second_dout", 32'(last_dout1), 32'hFF);
      chk("b2b_second_err", 32'(last_err1), 32'h0);
      repeat (BIT_CLK) @(negedge clk);

      // Five-tick low glitch must be rejected at the mid-start check.
      rx1 = 1'b0;
      repeat (20) @(negedge clk);
      rx1 = 1'b1;
      repeat (4 * BIT_CLK) @(negedge clk);
      chk("glitch_count", 32'(cnt1), 32'd3);
      chk("glitch_dout", 32'(dout1), 32'hFF);
      chk("glitch_idle", 32'(dut1.state_q), 32'(IDLE));

      // Asynchronous reset in the middle of data bit 3 of 0x5A.
      rx1 = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx1 = (i == 1) ? 1'b1 : 1'b0;
         repeat (BIT_CLK) @(negedge clk);
      end
      rx1 = 1'b1;
      repeat (BIT_CLK / 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_dout", 32'(dout1), 32'h0);
      chk("areset_done", 32'(done1), 32'h0);
      chk("areset_err", 32'(err1), 32'h0);
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      chk("areset_no_pulse", 32'(cnt1), 32'd3);
      send1(8'h5A, 1'b1);
      chk("after_reset_count", 32'(cnt1), 32'd4);
      chk("after_reset_dout", 32'(last_dout1), 32'h5A);
      repeat (BIT_CLK) @(negedge clk);

      // 0x3C with a low stop bit, then the line held low (break).
      base = cnt1;
      send1(8'h3C, 1'b0);
      chk("ferr_count", 32'(cnt1 - base), 32'd1);
      chk("ferr_dout", 32'(last_dout1), 32'h3C);
      chk("ferr_flag", 32'(last_err1), 32'h1);
      for (int i = 0; i < 2000 && cnt1 < base + 2; i++) @(negedge clk);
      rx1 = 1'b1;
      chk("break_count", 32'(cnt1 - base), 32'd2);
      chk("break_dout", 32'(last_dout1), 32'h00);
      chk("break_flag", 32'(last_err1), 32'h1);
      repeat (12 * BIT_CLK) @(negedge clk);
      chk("break_settled", 32'(cnt1 - base), 32'd2);

      // Seven data bits, two stop bits on the second instance.
      chk("dut2_quiet", 32'(cnt2), 32'd0);
      send2(7'h55);
      chk("d7_count", 32'(cnt2), 32'd1);
      chk("d7_dout", 32'(last_dout2), 32'h55);
      chk("d7_err", 32'(last_err2), 32'h0);
      chk_range("d7_latency", done_cyc2 - t0, LAT_MIN, LAT_MAX);

      repeat (BIT_CLK) @(negedge clk);
      chk("stray_err", 32'(stray), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_uart.md
Name: rx_uart

Overview:
UART receiver, the receive-side companion of the existing transmitter. It shares the same 16x oversampling tick and the same frame: 1 start bit, DBIT data bits LSB first, 1 stop bit. It synchronizes the asynchronous serial line, finds the start bit and samples each bit at mid-bit. It presents the received word with a one-cycle done pulse and flags a framing error.

Parameters:
DBIT, 8, data bits per frame (1..16)
SB_TICK, 16, oversampling ticks for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
NB_STATE, 2, state register width
SYNC_STAGES, 2, flops in the input synchronizer (>= 2)

Ports:
i_clock  input  1  system clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_s_tick  input  1  one-cycle strobe at 16x baud rate, from the baud generator
i_rx  input  1  serial line, asynchronous, idle high
o_dout  output  DBIT  last received word; held until the next frame completes
o_rx_done_tick  output  1  one-cycle pulse: frame complete, o_dout valid
o_frame_err  output  1  one-cycle pulse coincident with o_rx_done_tick when the stop bit sampled low

Behaviour:
- Reset: one clock, asynchronous, active-low. While i_reset_n=0, all state flops take their reset values immediately, independent of the clock.
  - State goes to IDLE; s, n and the shift register clear to 0.
  - Synchronizer flops reset to 1 (line idle).
  - o_dout=0, o_rx_done_tick=0, o_frame_err=0.
  - Reset mid-frame discards the partial frame. No done pulse is issued.
- Input path: i_rx passes through the SYNC_STAGES-flop synchronizer, giving rx_s. Only rx_s is used by the FSM. The synchronizer adds SYNC_STAGES cycles of latency.
- Counters:
  - s counts ticks; width is clog2 of max(16, SB_TICK).
  - n counts bits; width is clog2(DBIT), minimum 1.
  - Counters advance only in cycles with i_s_tick=1.
- FSM:
  - IDLE: when rx_s=0 (no tick needed), go to START with s=0.
  - START: on a tick with s==7 (mid start bit):
    - if rx_s=0, go to DATA with s=0, n=0;
    - if rx_s=1, treat as a glitch and return to IDLE with no outputs.
    - Otherwise each tick does s++.
  - DATA: on a tick with s==15:
    - shift rx_s into the shift register MSB, shifting right (LSB first on the line);
    - set s=0;
    - if n==DBIT-1 go to STOP, else n++.
    - Otherwise each tick does s++.
  - STOP: on a tick with s==SB_TICK-1 (mid stop bit), sample rx_s and go to IDLE.
    - In the next cycle: o_rx_done_tick=1, o_dout=shift register, and o_frame_err=1 if the sample was 0.
    - Otherwise each tick does s++.
- Output timing: o_rx_done_tick and o_frame_err are registered and high for exactly one clock.
- Returning to IDLE at mid stop bit lets back-to-back frames be received with no gap.
- Framing error: data is still delivered and the FSM still returns to IDLE.
  - If the line stays low (break), IDLE re-enters START at once.
  - Each full-length low period yields a frame of 0x00 with o_frame_err=1.
- No ticks: with i_s_tick=0 the FSM holds its state and counters indefinitely.

Decomposition:
- Shared uart_pkg holds:
  - state encodings IDLE=0, START=1, DATA=2, STOP=3 (width NB_STATE, shared with the transmitter);
  - OVERSAMPLE=16;
  - MID_TICK=7.
- One sub-module, sync_2ff: parameterized SYNC_STAGES bit synchronizer with async active-low reset to 1.
- FSM, counters and shift register stay in rx_uart, in the registered-state plus combinational-next-state style.

Test Plan:
1. Baud tick every 4 clocks. Send 0xA5 with a valid stop bit. Expect one o_rx_done_tick, o_dout=0xA5, o_frame_err=0, with the pulse arriving about SYNC_STAGES+1 cycles after the mid-stop-bit tick.
2. Send 0x00 then 0xFF back-to-back, with the next start bit immediately after the stop bit. Expect two pulses with o_dout=0x00 then 0xFF, and no errors.
3. Drive i_rx low for 5 ticks, then high. Expect the glitch rejected at the s==7 check, the FSM in IDLE, no pulse, and o_dout unchanged.
4. Send 0x3C with the stop bit driven 0. Expect the pulse, o_dout=0x3C and o_frame_err=1 in the same cycle. Hold the line low for a full frame time: expect a second pulse with 0x00 and o_frame_err=1.
5. Assert i_reset_n=0 asynchronously mid-DATA (bit 3 of 0x5A). Expect outputs 0 immediately, with no clock edge, and no pulse. Release reset and send 0x5A: expect o_dout=0x5A.
6. DBIT=7, SB_TICK=32 (two stop bits). Send 0x55. Expect the pulse at mid-second-stop-bit and o_dout=7'h55.
